// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank.
//
// Contents:
//   CNT_W_DEF      default counter width
//   CH_*           channel index map (channel 0 is the free-running cycle counter)
//   perf_state_e   bank state: RUN or FROZEN
package perf_pkg;

  localparam int CNT_W_DEF = 32;

  localparam int CH_CYCLE = 0;
  localparam int CH_INST  = 1;
  localparam int CH_IREQ  = 2;
  localparam int CH_IHIT  = 3;
  localparam int CH_DREQ  = 4;
  localparam int CH_DHIT  = 5;

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } perf_state_e;

endpackage

// File: rtl/perf_counter_cell.sv
// One event counter with a sticky overflow flag.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   clr   synchronous clear of count and overflow flag (same effect as rst)
//   inc   count one event this cycle
//   cnt   current count
//   ovf   sticky overflow flag, set on the edge where an all-ones count takes an event
//
// Build option: PERF_CNT_SAT_EN defined -> saturate at all-ones; undefined -> wrap to 0.
module perf_counter_cell #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (&cnt) begin
        ovf <= 1'b1;
`ifdef PERF_CNT_SAT_EN
        cnt <= cnt;
`else
        cnt <= '0;
`endif
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of per-channel event counters with halt freeze and registered readout.
//
// state  | meaning
// RUN    | counting enabled channels whenever count_en is high
// FROZEN | halt seen; counters hold until clear or rst
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset (also zeroes rd_data)
//   count_en  global enable; low pauses every channel including cycles
//   event_in  per-channel event strobes (bit 0 ignored, channel 0 counts cycles)
//   halt      processor halt; the halt cycle's events are still counted
//   clear     clears counters, overflow flags and state; wins over counting and halt
//   rd_sel    readout channel select
//   rd_data   counter[rd_sel] registered one cycle later; 0 for unused selects
//   ovf       sticky per-channel overflow flags
//   frozen    high while the bank is in FROZEN
//
// Build option: PERF_CNT_SAT_EN selects saturating counters (see perf_counter_cell).
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH = 6,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              count_en,
  input  logic [NUM_CH-1:0] event_in,
  input  logic              halt,
  input  logic              clear,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf,
  output logic              frozen
);

  perf_state_e       state_q, state_d;
  logic              count_act;
  logic [NUM_CH-1:0] inc;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [CNT_W-1:0]  rd_next;

  // Channel 0 counts cycles, so its strobe bit is deliberately left unused.
  wire ev0_unused = event_in[CH_CYCLE];

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear)                         state_d = RUN;
    else if (state_q == RUN && halt)   state_d = FROZEN;
  end

  assign frozen = (state_q == FROZEN);

  // Counting happens in the halt cycle too, since state is still RUN then.
  assign count_act = count_en && (state_q == RUN) && !clear;

  always_comb begin
    inc           = event_in & {NUM_CH{count_act}};
    inc[CH_CYCLE] = count_act;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    perf_counter_cell #(.CNT_W(CNT_W)) u_cell (
      .clk (clk),
      .rst (rst),
      .clr (clear),
      .inc (inc[i]),
      .cnt (cnt[i]),
      .ovf (ovf[i])
    );
  end

  // Selects beyond NUM_CH fall through to 0.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) rd_next = cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_next;
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;
  import perf_pkg::*;

  localparam int NUM_CH = 6;
  localparam int CNT_W  = 8;
  localparam int SEL_W  = 3;

`ifdef PERF_CNT_SAT_EN
  localparam int OVF_VAL   = 255;
  localparam int AFTER_10  = 255;
`else
  localparam int OVF_VAL   = 0;
  localparam int AFTER_10  = 10;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              count_en;
  logic [NUM_CH-1:0] event_in;
  logic              halt;
  logic              clear;
  logic [SEL_W-1:0]  rd_sel;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] ovf;
  logic              frozen;

  int n_chk = 0;
  int n_err = 0;

  perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .count_en (count_en),
    .event_in (event_in),
    .halt     (halt),
    .clear    (clear),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .ovf      (ovf),
    .frozen   (frozen)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Select a channel, wait one edge, compare the registered readout.
  task automatic rd_chk(input string tag, input int sel, input int exp);
    rd_sel = SEL_W'(sel);
    tick();
    chk(tag, int'(rd_data), exp);
  endtask

  initial begin
    rst = 1'b1; count_en = 1'b0; event_in = '0; halt = 1'b0; clear = 1'b0; rd_sel = '0;
    repeat (2) tick();
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_ovf",     int'(ovf), 0);
    chk("rst_frozen",  int'(frozen), 0);

    // basic count: 10 cycles with 5 inst events, then one quiet cycle
    rst = 1'b0; count_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      event_in = (k % 2 == 0) ? 6'b000010 : 6'b000000;
      tick();
    end
    event_in = '0;
    tick();
    count_en = 1'b0;
    rd_chk("basic_ch1", CH_INST, 5);
    rd_chk("basic_ch0", CH_CYCLE, 11);

    // halt with an event in the same cycle: event is counted
    count_en = 1'b1; event_in = 6'b000010; halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_frozen", int'(frozen), 1);
    event_in = '1;
    for (int k = 0; k < 20; k++) begin
      halt = (k % 3 == 0);
      tick();
    end
    halt = 1'b0; event_in = '0;
    rd_chk("frz_ch1", CH_INST, 6);
    rd_chk("frz_ch0", CH_CYCLE, 12);
    rd_chk("frz_ch2", CH_IREQ, 0);
    chk("frz_still", int'(frozen), 1);

    // clear from FROZEN with all events high
    count_en = 1'b1; event_in = '1; clear = 1'b1;
    tick();
    clear = 1'b0; count_en = 1'b0; event_in = '0;
    chk("clr_frozen", int'(frozen), 0);
    chk("clr_ovf",    int'(ovf), 0);
    rd_chk("clr_ch0", CH_CYCLE, 0);
    rd_chk("clr_ch1", CH_INST, 0);
    count_en = 1'b1; event_in = 6'b000100;
    repeat (3) tick();
    count_en = 1'b0; event_in = '0;
    rd_chk("resume_ch2", CH_IREQ, 3);
    rd_chk("resume_ch0", CH_CYCLE, 3);

    // clear in RUN with all events high: nothing counted
    count_en = 1'b1; event_in = '1; clear = 1'b1;
    tick();
    clear = 1'b0; count_en = 1'b0; event_in = '0;
    rd_chk("clrrun_ch0", CH_CYCLE, 0);
    rd_chk("clrrun_ch2", CH_IREQ, 0);

    // clear beats halt
    count_en = 1'b1; clear = 1'b1; halt = 1'b1;
    tick();
    clear = 1'b0; halt = 1'b0; count_en = 1'b0;
    chk("clr_vs_halt", int'(frozen), 0);

    // overflow on ch3 (ch0 overflows alongside it)
    count_en = 1'b1; event_in = 6'b001000;
    repeat (255) tick();
    chk("ovf_before", int'(ovf), 0);
    tick();
    chk("ovf_edge", int'(ovf), 6'b001001);
    count_en = 1'b0; event_in = '0;
    rd_chk("ovf_ch3", CH_IHIT, OVF_VAL);
    count_en = 1'b1; event_in = 6'b001000;
    repeat (10) tick();
    count_en = 1'b0; event_in = '0;
    rd_chk("ovf_ch3_10", CH_IHIT, AFTER_10);
    chk("ovf_sticky", int'(ovf), 6'b001001);

    // readout latency and out-of-range select
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("ovf_cleared", int'(ovf), 0);
    count_en = 1'b1; event_in = 6'b010000;
    repeat (4) tick();
    rd_chk("rd_lat_a", CH_DREQ, 4);
    tick();
    chk("rd_lat_b", int'(rd_data), 5);
    rd_chk("rd_sel7", 7, 0);
    rd_chk("rd_sel6", 6, 0);

    // pause with events high
    count_en = 1'b0; event_in = '1; rd_sel = SEL_W'(CH_DREQ);
    repeat (8) tick();
    chk("pause_ch4", int'(rd_data), 8);
    rd_chk("pause_ch0", CH_CYCLE, 8);

    // reset mid-run after halt
    count_en = 1'b1; event_in = '1;
    repeat (5) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("pre_rst_frozen", int'(frozen), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; count_en = 1'b0;
    chk("mid_rst_rd", int'(rd_data), 0);
    chk("mid_rst_frozen", int'(frozen), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    rd_chk("mid_rst_ch5", CH_DHIT, 0);

    // halt while paused: freezes, nothing counted
    halt = 1'b1;
    tick();
    halt = 1'b0; event_in = '0;
    chk("halt_paused", int'(frozen), 1);
    rd_chk("halt_paused_ch0", CH_CYCLE, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
